// File: rtl/push_arbiter.sv
// First-press arbiter for a two-player reaction game.
// Synchronizes both buttons, detects presses, and decides win or tie per round.
module push_arbiter #(
    parameter int TIE_WIN = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic pbl,
    input  logic pbr,
    input  logic clr,
    output logic winrnd,
    output logic right,
    output logic tie
);

    localparam int CW = (TIE_WIN < 1) ? 1 : $clog2(TIE_WIN + 1);
    localparam logic [CW-1:0] LAST = (TIE_WIN > 0) ? CW'(TIE_WIN - 1) : '0;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WINDOW = 2'd1,
        LOCK   = 2'd2
    } state_t;

    logic [1:0] sync_l;
    logic [1:0] sync_r;
    logic       prev_l;
    logic       prev_r;
    logic       edge_l;
    logic       edge_r;

    // Two-flop synchronizers plus a delayed copy for rising-edge detection
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_l <= '0;
            sync_r <= '0;
            prev_l <= 1'b0;
            prev_r <= 1'b0;
        end else begin
            sync_l <= {sync_l[0], pbl};
            sync_r <= {sync_r[0], pbr};
            prev_l <= sync_l[1];
            prev_r <= sync_r[1];
        end
    end

    assign edge_l = sync_l[1] & ~prev_l;
    assign edge_r = sync_r[1] & ~prev_r;

    state_t        state;
    state_t        state_n;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_n;
    logic          side;
    logic          side_n;
    logic          win_n;
    logic          right_n;
    logic          tie_n;
    logic          opp;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            cnt    <= '0;
            side   <= 1'b0;
            winrnd <= 1'b0;
            right  <= 1'b0;
            tie    <= 1'b0;
        end else begin
            state  <= state_n;
            cnt    <= cnt_n;
            side   <= side_n;
            winrnd <= win_n;
            right  <= right_n;
            tie    <= tie_n;
        end
    end

    // side = 1 means the right button opened the window
    assign opp = side ? edge_l : edge_r;

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        side_n  = side;
        win_n   = 1'b0;
        right_n = right;
        tie_n   = tie;
        if (clr) begin
            state_n = IDLE;
            cnt_n   = '0;
            side_n  = 1'b0;
            right_n = 1'b0;
            tie_n   = 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (edge_l && edge_r) begin
                        state_n = LOCK;
                        tie_n   = 1'b1;
                        right_n = 1'b0;
                        win_n   = 1'b1;
                    end else if (edge_l || edge_r) begin
                        if (TIE_WIN == 0) begin
                            state_n = LOCK;
                            right_n = edge_r;
                            tie_n   = 1'b0;
                            win_n   = 1'b1;
                        end else begin
                            state_n = WINDOW;
                            side_n  = edge_r;
                            cnt_n   = '0;
                        end
                    end
                end
                WINDOW: begin
                    // Counter stops one short of TIE_WIN, so it never wraps
                    if (opp) begin
                        state_n = LOCK;
                        tie_n   = 1'b1;
                        right_n = 1'b0;
                        win_n   = 1'b1;
                    end else if (cnt == LAST) begin
                        state_n = LOCK;
                        right_n = side;
                        tie_n   = 1'b0;
                        win_n   = 1'b1;
                    end else begin
                        cnt_n = cnt + CW'(1);
                    end
                end
                LOCK: begin
                    state_n = LOCK;
                end
                default: begin
                    state_n = IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_push_arbiter.sv
// Directed bench for push_arbiter: per-cycle vector table plus
// hand sequences for reset behaviour and the zero-window variant.
module tb_push_arbiter;

    logic clk = 1'b0;
    logic rst;
    logic pbl, pbr, clr;
    logic winrnd, right, tie;
    logic pbl0, pbr0, clr0;
    logic winrnd0, right0, tie0;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    push_arbiter #(.TIE_WIN(2)) dut (
        .clk(clk), .rst(rst), .pbl(pbl), .pbr(pbr), .clr(clr),
        .winrnd(winrnd), .right(right), .tie(tie)
    );

    push_arbiter #(.TIE_WIN(0)) dut0 (
        .clk(clk), .rst(rst), .pbl(pbl0), .pbr(pbr0), .clr(clr0),
        .winrnd(winrnd0), .right(right0), .tie(tie0)
    );

    typedef struct {
        logic pl;
        logic pr;
        logic c;
        logic w;
        logic r;
        logic t;
    } vec_t;

    vec_t tbl[$];

    function automatic void add(logic pl, logic pr, logic c,
                                logic w, logic r, logic t);
        vec_t v;
        v.pl = pl; v.pr = pr; v.c = c;
        v.w = w; v.r = r; v.t = t;
        tbl.push_back(v);
    endfunction

    task automatic chk(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic chk_int(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Cycles until winrnd on the TIE_WIN=2 instance; 0 if none within 10
    task automatic wait_win(output int n);
        n = 0;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            if (winrnd && n == 0) n = k;
        end
    endtask

    task automatic wait_win0(output int n);
        n = 0;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            if (winrnd0 && n == 0) n = k;
        end
    endtask

    task automatic step(input int n);
        for (int k = 0; k < n; k++) @(negedge clk);
    endtask

    int n;
    int wins;

    initial begin
        rst = 1'b1;
        pbl = 0; pbr = 0; clr = 0;
        pbl0 = 0; pbr0 = 0; clr0 = 0;

        // Row i: inputs seen at edge i, outputs expected after edge i
        add(1,0,0, 0,0,0); add(1,0,0, 0,0,0); add(0,0,0, 0,0,0);
        add(0,0,0, 0,0,0); add(0,0,0, 1,0,0); add(0,0,0, 0,0,0);
        add(0,0,1, 0,0,0);
        add(0,1,0, 0,0,0); add(0,0,0, 0,0,0); add(0,0,0, 0,0,0);
        add(0,0,0, 0,0,0); add(0,0,0, 1,1,0); add(0,0,0, 0,1,0);
        add(0,0,1, 0,0,0);
        add(0,1,0, 0,0,0); add(1,1,0, 0,0,0); add(1,1,0, 0,0,0);
        add(0,0,0, 1,0,1); add(0,0,0, 0,0,1); add(0,0,1, 0,0,0);
        add(1,1,0, 0,0,0); add(0,0,0, 0,0,0); add(0,0,0, 1,0,1);
        add(0,0,0, 0,0,1);
        add(0,1,0, 0,0,1); add(0,0,0, 0,0,1); add(0,1,0, 0,0,1);
        add(0,0,0, 0,0,1); add(0,1,0, 0,0,1); add(0,0,0, 0,0,1);
        add(0,0,0, 0,0,1);
        add(0,1,0, 0,0,1); add(0,1,0, 0,0,1); add(0,1,1, 0,0,0);
        add(0,1,0, 0,0,0); add(0,1,0, 0,0,0); add(0,1,0, 0,0,0);
        add(0,0,0, 0,0,0); add(0,1,0, 0,0,0); add(0,0,0, 0,0,0);
        add(0,0,0, 0,0,0); add(0,0,0, 0,0,0); add(0,0,0, 1,1,0);
        add(0,0,0, 0,1,0); add(0,0,1, 0,0,0);
        add(1,0,0, 0,0,0); add(0,0,0, 0,0,0); add(0,1,0, 0,0,0);
        add(0,0,0, 0,0,0); add(0,0,0, 1,0,1); add(0,0,0, 0,0,1);
        add(0,0,1, 0,0,0);
        add(1,0,0, 0,0,0); add(0,0,0, 0,0,0); add(0,0,0, 0,0,0);
        add(0,1,0, 0,0,0); add(0,0,0, 1,0,0); add(0,0,0, 0,0,0);
        add(0,0,1, 0,0,0);
        add(1,0,0, 0,0,0); add(0,0,0, 0,0,0); add(1,0,0, 0,0,0);
        add(0,0,0, 0,0,0); add(0,0,0, 1,0,0); add(0,0,0, 0,0,0);
        add(0,0,1, 0,0,0);

        step(2);
        chk("reset winrnd", winrnd, 1'b0);
        chk("reset right", right, 1'b0);
        chk("reset tie", tie, 1'b0);
        rst = 1'b0;
        step(3);

        foreach (tbl[i]) begin
            pbl = tbl[i].pl;
            pbr = tbl[i].pr;
            clr = tbl[i].c;
            @(negedge clk);
            chk($sformatf("row%0d winrnd", i), winrnd, tbl[i].w);
            chk($sformatf("row%0d right", i), right, tbl[i].r);
            chk($sformatf("row%0d tie", i), tie, tbl[i].t);
        end
        pbl = 0; pbr = 0; clr = 0;
        step(2);

        // Button held through reset release counts as a press
        rst = 1'b1;
        pbr = 1'b1;
        step(1);
        rst = 1'b0;
        wait_win(n);
        chk_int("held-reset latency", n, 5);
        chk("held-reset right", right, 1'b1);
        clr = 1'b1; step(1);
        clr = 1'b0; pbr = 1'b0; step(3);
        chk("after clr right", right, 1'b0);

        // Asynchronous reset in the middle of a window
        pbl = 1'b1; step(1);
        pbl = 1'b0; step(2);
        #2 rst = 1'b1;
        #1;
        chk("midwin rst winrnd", winrnd, 1'b0);
        chk("midwin rst right", right, 1'b0);
        chk("midwin rst tie", tie, 1'b0);
        #1 rst = 1'b0;
        wait_win(n);
        chk_int("midwin abandoned", n, 0);
        pbr = 1'b1; step(1);
        pbr = 1'b0;
        wait_win(n);
        chk_int("post-rst latency", n, 4);
        chk("post-rst right", right, 1'b1);
        chk("post-rst tie", tie, 1'b0);
        clr = 1'b1; step(1);
        clr = 1'b0; step(2);

        // Asynchronous reset while locked on a tie
        pbl = 1'b1; pbr = 1'b1; step(1);
        pbl = 1'b0; pbr = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("tie winrnd", winrnd, 1'b1);
        chk("tie flag", tie, 1'b1);
        step(1);
        #2 rst = 1'b1;
        #1;
        chk("lock rst tie", tie, 1'b0);
        chk("lock rst winrnd", winrnd, 1'b0);
        #1 rst = 1'b0;
        wins = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (winrnd) wins++;
        end
        chk_int("lock rst no pulse", wins, 0);
        chk("lock rst tie stays", tie, 1'b0);

        // Zero-window instance decides straight from IDLE
        pbr0 = 1'b1; step(1);
        pbr0 = 1'b0;
        wait_win0(n);
        chk_int("tw0 right latency", n, 2);
        chk("tw0 right", right0, 1'b1);
        chk("tw0 tie", tie0, 1'b0);
        clr0 = 1'b1; step(1);
        clr0 = 1'b0; step(1);
        pbl0 = 1'b1; step(1);
        pbl0 = 1'b0;
        wait_win0(n);
        chk_int("tw0 left latency", n, 2);
        chk("tw0 left right", right0, 1'b0);
        chk("tw0 left tie", tie0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/push_arbiter.md
PUSH_ARBITER -- requirements
Module: push_arbiter

Interface
REQ-001 SHALL have parameter TIE_WIN, default 2, meaning the tie window in clock cycles after the first accepted press (0 = only same-cycle presses tie).
REQ-002 SHALL have port clk  input  1  system clock; all state changes on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port pbl  input  1  left player pushbutton, asynchronous to clk, level.
REQ-005 SHALL have port pbr  input  1  right player pushbutton, asynchronous to clk, level.
REQ-006 SHALL have port clr  input  1  synchronous round clear; re-arms the arbiter.
REQ-007 SHALL have port winrnd  output  1  one-cycle pulse: round decided; feeds scorer winrnd.
REQ-008 SHALL have port right  output  1  1 = right player won the round; feeds scorer right.
REQ-009 SHALL have port tie  output  1  1 = round tied; feeds scorer tie.

Function
REQ-010 SHALL pass pbl and pbr each through a 2-flop synchronizer, then a rising-edge detector (sync2 & ~prev); a held button SHALL produce exactly one edge pulse.
REQ-011 SHALL give a press set up before clk edge N its edge pulse in the cycle between edges N+1 and N+2.
REQ-012 SHALL implement states IDLE, WINDOW, LOCK.
REQ-013 IDLE: both edge pulses in the same cycle -> LOCK with tie=1, right=0, winrnd pulse.
REQ-014 IDLE: exactly one edge pulse with TIE_WIN=0 -> LOCK with right=(pulse was pbr), tie=0, winrnd pulse.
REQ-015 IDLE: exactly one edge pulse with TIE_WIN>0 -> WINDOW; record the first side; window counter := 0.
REQ-016 WINDOW: counter increments each cycle; an opposite-side edge pulse while counter < TIE_WIN -> LOCK with tie=1, right=0, winrnd pulse.
REQ-017 WINDOW: counter reaches TIE_WIN with no opposite pulse -> LOCK with right=recorded side, tie=0, winrnd pulse.
REQ-018 WINDOW: further same-side pulses SHALL be ignored.
REQ-019 LOCK: all edge pulses SHALL be ignored; right/tie SHALL hold; winrnd=0.
REQ-020 winrnd, right and tie SHALL all be registered outputs; winrnd SHALL be high for exactly 1 cycle per round.
REQ-021 Latency: single press at edge N -> winrnd high from edge N+2 (TIE_WIN=0) or from edge N+2+TIE_WIN (TIE_WIN>0).
REQ-022 clr=1 at a clock edge SHALL force IDLE, right=0, tie=0, winrnd=0 and counter=0, with priority over any same-cycle edge pulse (that pulse is discarded).
REQ-023 A button still held across clr SHALL NOT start a new round; only a fresh release-then-press SHALL.
REQ-024 The counter SHALL be sized ceil(log2(TIE_WIN+1)) bits, minimum 1, and SHALL never wrap.

Reset
REQ-025 rst=1 SHALL immediately force IDLE, winrnd=0, right=0, tie=0, counter=0 and all synchronizer/edge flops to 0, regardless of clk.
REQ-026 A button held through reset release SHALL register as a press in the first cycles after reset (prev flop resets to 0).
REQ-027 Reset asserted mid-WINDOW or mid-LOCK SHALL abandon the round with no winrnd pulse.

Verification
REQ-028 TIE_WIN=2; pbl rises at edge 10 and is held 2 cycles -> winrnd=1 for the one cycle after edge 14; right=0, tie=0 held until clr.
REQ-029 TIE_WIN=2; pbr at edge 10, pbl at edge 11 -> winrnd pulse after edge 13; tie=1, right=0.
REQ-030 pbl and pbr rise in the same cycle -> winrnd pulse; tie=1; then clr for 1 cycle -> right=0, tie=0, state IDLE.
REQ-031 In LOCK, 3 pbr presses -> no winrnd; outputs unchanged; pbr held across clr -> no new round until a release and re-press.
REQ-032 rst pulsed mid-WINDOW -> all outputs 0 asynchronously and no winrnd pulse afterwards; next pbr press -> right=1 round.
